// File: rtl/microcode_sequencer.sv
// Microcode sequencer: steps the opcode decoder through fetch and execute phases and issues micro-op fire strobes.
// Optional single-step hold (inputs step_mode/step_req) is enabled by defining MICROSEQ_SINGLE_STEP_EN.
package OpcodePackage;
   typedef enum logic [7:0] {
      NXI  = 8'h00,
      ATB  = 8'h01,
      GPU  = 8'h02,
      WFT  = 8'h03,
      DDW  = 8'h04,
      HLT  = 8'h05,
      LOOP = 8'h06
   } Opcode_enum;
endpackage

package MicrocodePackage;
   typedef enum logic [5:0] {
      ENDMICRO,
      HLT_CLK,
      WAIT_GPU,
      WAIT_DD,
      WAIT_MT,
      WAIT_UT,
      WAIT_FT,
      INC_PC,
      PC_to_MAR,
      MEM_READ,
      RAM_to_IR,
      A_to_B,
      START_GPU,
      NOP_U
   } Microcode_enum;
endpackage

module microcode_sequencer
   import OpcodePackage::*;
   import MicrocodePackage::*;
#(
   parameter logic [5:0] CYCLE_MAX = 6'd63
) (
   input  logic          clk,
   input  logic          reset,
`ifdef MICROSEQ_SINGLE_STEP_EN
   input  logic          step_mode,
   input  logic          step_req,
`endif
   input  Opcode_enum    ir,
   input  Microcode_enum ucode,
   input  logic          gpu_busy,
   input  logic          dd_busy,
   input  logic          mt_busy,
   input  logic          ut_busy,
   input  logic          ft_tick,
   output Opcode_enum    operation,
   output logic [5:0]    cycle,
   output logic          uop_fire,
   output logic          phase,
   output logic          retire,
   output logic          halted,
   output logic          fault
);

   typedef enum logic [1:0] {
      S_FETCH,
      S_EXEC,
      S_HALTED
`ifdef MICROSEQ_SINGLE_STEP_EN
      , S_STEP_HOLD
`endif
   } state_t;

   state_t     state_q, state_n;
   Opcode_enum op_n;
   logic [5:0] cycle_n;
   logic       phase_n, halted_n, fault_n;
   logic       stall, end_phase, step_hold_en;

`ifdef MICROSEQ_SINGLE_STEP_EN
   assign step_hold_en = step_mode;
`else
   assign step_hold_en = 1'b0;
`endif

   assign stall = (ucode == WAIT_GPU && gpu_busy) ||
                  (ucode == WAIT_DD  && dd_busy)  ||
                  (ucode == WAIT_MT  && mt_busy)  ||
                  (ucode == WAIT_UT  && ut_busy)  ||
                  (ucode == WAIT_FT  && !ft_tick);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         operation <= NXI;
         cycle     <= 6'd0;
         phase     <= 1'b0;
         halted    <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state_q   <= state_n;
         operation <= op_n;
         cycle     <= cycle_n;
         phase     <= phase_n;
         halted    <= halted_n;
         fault     <= fault_n;
      end
   end

   always_comb begin
      state_n   = state_q;
      op_n      = operation;
      cycle_n   = cycle;
      phase_n   = phase;
      halted_n  = halted;
      fault_n   = fault;
      uop_fire  = 1'b0;
      retire    = 1'b0;
      end_phase = 1'b0;
      case (state_q)
         S_FETCH, S_EXEC: begin
            if (!stall) begin
               if (ucode == HLT_CLK) begin
                  uop_fire = 1'b1;
                  halted_n = 1'b1;
                  state_n  = S_HALTED;
               end else begin
                  // A uop landing on the last legal cycle still fires, then the phase is forced closed.
                  end_phase = (ucode == ENDMICRO) || (cycle == CYCLE_MAX);
                  uop_fire  = (ucode != ENDMICRO);
                  if (ucode != ENDMICRO && cycle == CYCLE_MAX)
                     fault_n = 1'b1;
                  if (end_phase) begin
                     cycle_n = 6'd0;
                     if (state_q == S_FETCH) begin
                        state_n = S_EXEC;
                        op_n    = ir;
                        phase_n = 1'b1;
                     end else begin
                        op_n    = NXI;
                        phase_n = 1'b0;
                        retire  = (ucode == ENDMICRO);
`ifdef MICROSEQ_SINGLE_STEP_EN
                        state_n = (ucode == ENDMICRO && step_hold_en) ? S_STEP_HOLD : S_FETCH;
`else
                        state_n = step_hold_en ? S_EXEC : S_FETCH;
`endif
                     end
                  end else begin
                     cycle_n = cycle + 6'd1;
                  end
               end
            end
         end
         S_HALTED: begin
         end
`ifdef MICROSEQ_SINGLE_STEP_EN
         S_STEP_HOLD: begin
            phase_n = 1'b0;
            if (step_req)
               state_n = S_FETCH;
         end
`endif
         default: state_n = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Testbench for microcode_sequencer: a behavioural decoder feeds ucode, a queue holds per-clock expected outputs.
// Exercises the MICROSEQ_SINGLE_STEP_EN hold path when that macro is defined.
module tb_microcode_sequencer;
   import OpcodePackage::*;
   import MicrocodePackage::*;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   Opcode_enum    ir = NXI;
   Microcode_enum ucode;
   logic          gpu_busy = 1'b0, dd_busy = 1'b0, mt_busy = 1'b0, ut_busy = 1'b0, ft_tick = 1'b0;
   Opcode_enum    operation;
   logic [5:0]    cycle;
   logic          uop_fire, phase, retire, halted, fault;
`ifdef MICROSEQ_SINGLE_STEP_EN
   logic          step_mode = 1'b0, step_req = 1'b0;
`endif

   logic [18:0]   exp_q[$];
   string         tag_q[$];
   int            n_cmp = 0;
   int            n_bad = 0;

   microcode_sequencer dut (
      .clk       (clk),
      .reset     (reset),
`ifdef MICROSEQ_SINGLE_STEP_EN
      .step_mode (step_mode),
      .step_req  (step_req),
`endif
      .ir        (ir),
      .ucode     (ucode),
      .gpu_busy  (gpu_busy),
      .dd_busy   (dd_busy),
      .mt_busy   (mt_busy),
      .ut_busy   (ut_busy),
      .ft_tick   (ft_tick),
      .operation (operation),
      .cycle     (cycle),
      .uop_fire  (uop_fire),
      .phase     (phase),
      .retire    (retire),
      .halted    (halted),
      .fault     (fault)
   );

   always #5 clk = ~clk;

   function automatic Microcode_enum decode(input Opcode_enum op, input logic [5:0] cy);
      Microcode_enum u;
      u = ENDMICRO;
      case (op)
         NXI: case (cy)
            6'd0: u = INC_PC;
            6'd1: u = PC_to_MAR;
            6'd2: u = MEM_READ;
            6'd3: u = RAM_to_IR;
            default: u = ENDMICRO;
         endcase
         ATB: u = (cy == 6'd0) ? A_to_B : ENDMICRO;
         GPU: u = (cy == 6'd0) ? WAIT_GPU : (cy == 6'd1) ? START_GPU : ENDMICRO;
         WFT: u = (cy == 6'd0) ? WAIT_FT : ENDMICRO;
         DDW: case (cy)
            6'd0: u = WAIT_DD;
            6'd1: u = WAIT_MT;
            6'd2: u = WAIT_UT;
            default: u = ENDMICRO;
         endcase
         HLT: u = HLT_CLK;
         LOOP: u = NOP_U;
         default: u = ENDMICRO;
      endcase
      return u;
   endfunction

   assign ucode = decode(operation, cycle);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h ({fire,retire,phase,halted,fault,cycle,op})", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, queue the expectation, sample mid-period, then advance past the next edge.
   task automatic clk_step(input string tag, input logic [4:0] bsy, input logic uf, input logic rt,
                           input logic ph, input logic hl, input logic flt, input logic [5:0] cy,
                           input Opcode_enum op);
      logic [18:0] got;
      {gpu_busy, dd_busy, mt_busy, ut_busy, ft_tick} = bsy;
      exp_q.push_back({uf, rt, ph, hl, flt, cy, 8'(op)});
      tag_q.push_back(tag);
      #1;
      got = {uop_fire, retire, phase, halted, fault, cycle, 8'(operation)};
      check(tag_q.pop_front(), 32'(got), 32'(exp_q.pop_front()));
      @(posedge clk);
      #1;
   endtask

   task automatic do_fetch(input Opcode_enum nxt, input logic flt, input logic [4:0] bsy, input int tick_c);
      ir = nxt;
      for (int c = 0; c < 5; c++)
         clk_step($sformatf("fetch_c%0d", c), (c == tick_c) ? (bsy | 5'b00001) : bsy,
                  (c < 4), 1'b0, 1'b0, 1'b0, flt, 6'(c), NXI);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      do_fetch(ATB, 1'b0, 5'd0, -1);
      clk_step("atb_c0",  5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, ATB);
      clk_step("atb_end", 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd1, ATB);

      do_fetch(GPU, 1'b0, 5'b10000, -1);
      for (int i = 0; i < 10; i++)
         clk_step($sformatf("gpu_stall%0d", i), 5'b10000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, GPU);
      clk_step("gpu_wait_fire", 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, GPU);
      clk_step("gpu_start",     5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1, GPU);
      clk_step("gpu_end",       5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd2, GPU);

      do_fetch(WFT, 1'b0, 5'd0, 4);
      for (int i = 0; i < 3; i++)
         clk_step($sformatf("wft_stall%0d", i), 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, WFT);
      clk_step("wft_fire", 5'b00001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, WFT);
      clk_step("wft_end",  5'd0,     1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd1, WFT);

      do_fetch(DDW, 1'b0, 5'd0, -1);
      clk_step("dd_stall0", 5'b01000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, DDW);
      clk_step("dd_stall1", 5'b01000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, DDW);
      clk_step("dd_fire",   5'b00100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, DDW);
      clk_step("mt_stall",  5'b00100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1, DDW);
      clk_step("mt_fire",   5'b00010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1, DDW);
      clk_step("ut_stall",  5'b00010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd2, DDW);
      clk_step("ut_fire",   5'd0,     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd2, DDW);
      clk_step("ddw_end",   5'd0,     1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd3, DDW);

      do_fetch(HLT, 1'b0, 5'd0, -1);
      clk_step("hlt_fire", 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, HLT);
      for (int i = 0; i < 20; i++)
         clk_step($sformatf("halted%0d", i), 5'($urandom), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0, HLT);
      do_reset();

      do_fetch(GPU, 1'b0, 5'd0, -1);
      for (int i = 0; i < 3; i++)
         clk_step($sformatf("pre_rst_stall%0d", i), 5'b10000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, GPU);
      gpu_busy = 1'b1;
      do_reset();

      do_fetch(LOOP, 1'b0, 5'b10000, -1);
      for (int c = 0; c < 64; c++)
         clk_step($sformatf("loop_c%0d", c), 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'(c), LOOP);
      do_fetch(ATB, 1'b1, 5'd0, -1);
      clk_step("flt_atb_c0",  5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 6'd0, ATB);
      clk_step("flt_atb_end", 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'd1, ATB);
      do_reset();

      do_fetch(ATB, 1'b0, 5'd0, -1);
      clk_step("post_atb_c0",  5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, ATB);
`ifdef MICROSEQ_SINGLE_STEP_EN
      step_mode = 1'b1;
      clk_step("step_atb_end", 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd1, ATB);
      for (int i = 0; i < 3; i++)
         clk_step($sformatf("hold%0d", i), 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, NXI);
      step_req = 1'b1;
      clk_step("hold_req", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, NXI);
      step_req = 1'b0;
      do_fetch(ATB, 1'b0, 5'd0, -1);
      clk_step("step2_c0",  5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, ATB);
      clk_step("step2_end", 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd1, ATB);
      clk_step("hold_again", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, NXI);
      clk_step("hold_again2", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, NXI);
`else
      clk_step("post_atb_end", 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd1, ATB);
      clk_step("post_fetch_c0", 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, NXI);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/microcode_sequencer.md
# microcode_sequencer

- Drives the combinational opcode-to-microcode decoder: supplies the `operation` and `cycle` inputs, consumes the returned `ucode`, and issues per-cycle micro-op fire strobes to the datapath.
- Alternates between an instruction-fetch phase (operation NXI) and an execute phase (operation = instruction register).
- Stalls on the WAIT_* micro-ops, retires instructions on ENDMICRO, and halts on HLT_CLK.
- Sits in the CPU control path between the IR, the decoder and the datapath control-signal expander.

## Interface
Parameters:
- CYCLE_MAX, 6'd63 — last legal micro-cycle index; reaching it without ENDMICRO is a fault.

Ports (widths: Opcode_enum / Microcode_enum from OpcodePackage / MicrocodePackage):
- clk  in  1  — system clock.
- reset  in  1  — synchronous, active-high reset.
- ir  in  Opcode_enum  — current instruction register contents.
- ucode  in  Microcode_enum  — decoder output for (operation, cycle), same cycle.
- gpu_busy  in  1  — GPU busy; stalls WAIT_GPU.
- dd_busy  in  1  — BCD/double-dabble busy; stalls WAIT_DD.
- mt_busy  in  1  — ms timer running; stalls WAIT_MT.
- ut_busy  in  1  — us timer running; stalls WAIT_UT.
- ft_tick  in  1  — one-clock frame-timer pulse; releases WAIT_FT.
- operation  out  Opcode_enum  — to decoder (registered).
- cycle  out  6  — to decoder (registered).
- uop_fire  out  1  — `ucode` is to be executed by the datapath this clock.
- phase  out  1  — 0 = FETCH, 1 = EXEC.
- retire  out  1  — one-clock pulse on the EXEC-phase ENDMICRO.
- halted  out  1  — set after HLT_CLK.
- fault  out  1  — sticky micro-cycle overflow flag.

## Operation
State machine: FETCH, EXEC, HALTED, plus STEP_HOLD when configured.

FETCH and EXEC, evaluated each clock on the current `ucode`:
- **Stall:** ucode is WAIT_GPU & gpu_busy, WAIT_DD & dd_busy, WAIT_MT & mt_busy, WAIT_UT & ut_busy, or WAIT_FT & !ft_tick.
  - uop_fire = 0; cycle and operation hold.
- **ENDMICRO:**
  - uop_fire = 0; cycle ← 0.
  - In FETCH: → EXEC, operation ← ir.
  - In EXEC: → FETCH, operation ← NXI, retire = 1.
- **HLT_CLK:** uop_fire = 1; → HALTED.
- **Overflow:** any other ucode with cycle == CYCLE_MAX.
  - uop_fire = 1; fault ← 1.
  - Phase ends as if ENDMICRO followed: EXEC → FETCH, FETCH → EXEC.
- **Otherwise:** uop_fire = 1; cycle ← cycle + 1.
- A non-stalled WAIT_* fires like any other uop; the datapath treats it as a no-op.

HALTED:
- uop_fire = 0; all outputs hold; ucode and busy inputs are ignored.
- Exits only by reset.

General rules:
- `ir` is sampled only on the FETCH→EXEC transition. RAM_to_IR executes at fetch cycle 3, so `ir` is stable by the ENDMICRO at fetch cycle 4.
- Simultaneous stall condition and reset: reset wins.
- ft_tick arriving on a non-WAIT_FT cycle is not remembered.

## Timing
- Reset values: operation = NXI, cycle = 0, phase = 0, uop_fire follows the decoder (INC_PC at reset exit), retire = 0, halted = 0, fault = 0.
- Reset applies at any point, including mid-stall or while HALTED; the next clock is fetch cycle 0.
- operation, cycle, phase, halted and fault are registered.
- uop_fire and retire are combinational from the registered state, `ucode` and the busy inputs. No cross-clock paths.
- ENDMICRO costs one clock in which no uop fires.
- Fetch = 5 clocks (4 uops + ENDMICRO). A 1-uop instruction = 2 clocks. Instruction total = 5 + N + 1 clocks with no stalls.
- A stall ends in the clock where its busy input deasserts: that clock fires the WAIT uop and advances.

## Configuration
Macro: MICROSEQ_SINGLE_STEP_EN.
- **Defined:**
  - Adds inputs step_mode (1) and step_req (1) and state STEP_HOLD.
  - On the EXEC ENDMICRO with step_mode = 1, go to STEP_HOLD instead of FETCH. retire still pulses; operation ← NXI, cycle ← 0.
  - In STEP_HOLD: uop_fire = 0 and phase = 0. A clock with step_req = 1 enters FETCH; fetch cycle 0 runs on the following clock.
  - step_mode = 0 never enters STEP_HOLD.
- **Undefined:** ports and state absent; behaviour identical to the defined case with step_mode = 0.

## Test plan
- Reset, then ir = ATB with the real decoder → uop_fire high at fetch cycles 0–3; phase 1 at clock 5; A_to_B fires at clock 5; retire pulses at clock 6; operation = NXI, cycle = 0 at clock 7.
- GPU instruction with gpu_busy held high 10 clocks after reaching exec cycle 0 → cycle stays 0 and uop_fire = 0 for 10 clocks; WAIT_GPU fires on clock 11; START_GPU fires next.
- WFT with ft_tick pulsing 3 clocks into the wait → exactly 3 stall clocks, then advance; a ft_tick pulse before the WAIT_FT clock has no effect.
- HLT → halted = 1 the clock after HLT_CLK fires; outputs frozen for 20 clocks; reset → operation = NXI, cycle = 0, halted = 0.
- Stub decoder that never returns ENDMICRO in EXEC → at cycle 63 fault = 1 and the next clock is FETCH cycle 0; fault stays high until reset.
- With MICROSEQ_SINGLE_STEP_EN and step_mode = 1 → after retire the sequencer idles in STEP_HOLD; a step_req pulse starts exactly one fetch + execute, then it returns to STEP_HOLD.
